// File: rtl/logic_shift_arbiter.sv
// Two-requester round-robin arbiter sharing one combinational logic_shift datapath.
// One request is accepted in IDLE, its result is held in BUSY until the consumer takes it.

module logic_shift #(
  parameter int BIT_NUM       = 8,
  parameter int SHIFT_BIT_NUM = 3
) (
  input  logic [BIT_NUM-1:0]       data_i,
  input  logic [SHIFT_BIT_NUM-1:0] shift_i,
  input  logic                     right_i,
  output logic [BIT_NUM-1:0]       data_o
);

  // Both shift operators zero-fill, giving logical shifts in either direction.
  assign data_o = right_i ? (data_i >> shift_i) : (data_i << shift_i);

endmodule

module logic_shift_arbiter #(
  parameter int BIT_NUM       = 8,
  parameter int SHIFT_BIT_NUM = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid_0,
  input  logic                     req_valid_1,
  output logic                     req_ready_0,
  output logic                     req_ready_1,
  input  logic [BIT_NUM-1:0]       req_data_0,
  input  logic [BIT_NUM-1:0]       req_data_1,
  input  logic [SHIFT_BIT_NUM-1:0] req_shift_0,
  input  logic [SHIFT_BIT_NUM-1:0] req_shift_1,
  input  logic                     req_right_0,
  input  logic                     req_right_1,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BIT_NUM-1:0]       rsp_data,
  output logic                     rsp_id,
  output logic                     busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e               state_q;
  logic                 last_grant_q;
  logic [BIT_NUM-1:0]   rsp_data_q;
  logic                 rsp_id_q;

  logic                     grant_1;
  logic                     accept;
  logic [BIT_NUM-1:0]       sel_data;
  logic [SHIFT_BIT_NUM-1:0] sel_shift;
  logic                     sel_right;
  logic [BIT_NUM-1:0]       shift_out;

  // On contention the requester that did not win last time is granted.
  always_comb begin
    // NOTE: default assignment first so every path drives grant_1 and no latch is inferred.
    grant_1 = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      grant_1 = ~last_grant_q;
    end else begin
      grant_1 = req_valid_1;
    end
  end

  // Ready is suppressed during reset so nothing is accepted on a reset edge.
  assign accept      = (state_q == IDLE) && !reset && (req_valid_0 || req_valid_1);
  assign req_ready_0 = accept && !grant_1;
  assign req_ready_1 = accept &&  grant_1;

  assign sel_data  = grant_1 ? req_data_1  : req_data_0;
  assign sel_shift = grant_1 ? req_shift_1 : req_shift_0;
  assign sel_right = grant_1 ? req_right_1 : req_right_0;

  logic_shift #(
    .BIT_NUM      (BIT_NUM),
    .SHIFT_BIT_NUM(SHIFT_BIT_NUM)
  ) u_shift (
    .data_i (sel_data),
    .shift_i(sel_shift),
    .right_i(sel_right),
    .data_o (shift_out)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= BUSY;
            last_grant_q <= grant_1;
            rsp_data_q   <= shift_out;
            rsp_id_q     <= grant_1;
          end
        end
        BUSY: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_q == BUSY);
  assign busy      = (state_q == BUSY);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_logic_shift_arbiter.sv
// Self-checking bench for logic_shift_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.

module tb_logic_shift_arbiter;

  logic       clk;
  logic       reset;
  logic       req_valid_0, req_valid_1;
  logic       req_ready_0, req_ready_1;
  logic [7:0] req_data_0, req_data_1;
  logic [2:0] req_shift_0, req_shift_1;
  logic       req_right_0, req_right_1;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic_shift_arbiter #(.BIT_NUM(8), .SHIFT_BIT_NUM(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid_0(req_valid_0),
    .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0),
    .req_ready_1(req_ready_1),
    .req_data_0 (req_data_0),
    .req_data_1 (req_data_1),
    .req_shift_0(req_shift_0),
    .req_shift_1(req_shift_1),
    .req_right_0(req_right_0),
    .req_right_1(req_right_1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Logical shift by plain arithmetic: multiply/divide by 2**amt, truncate to 8 bits.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                           input logic rt);
    int v, p;
    v = int'(d);
    p = 1 << s;
    return rt ? 8'(v / p) : 8'((v * p) % 256);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input logic [7:0] d, input logic [2:0] s, input logic rt);
    if (id == 1'b0) begin
      req_valid_0 = 1'b1; req_data_0 = d; req_shift_0 = s; req_right_0 = rt;
    end else begin
      req_valid_1 = 1'b1; req_data_1 = d; req_shift_1 = s; req_right_1 = rt;
    end
  endtask

  task automatic idle_inputs();
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_data_0 = 8'h00; req_data_1 = 8'h00;
    req_shift_0 = 3'd0; req_shift_1 = 3'd0;
    req_right_0 = 1'b0; req_right_1 = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rsp_ready = 1'b0;
    reset = 1'b1;
    issue(0, 8'hAA, 3'd1, 1'b0);
    #1;
    n_tests++;
    if (req_ready_0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready0: got %b want 0", req_ready_0);
    end
    step();
    step();
    n_tests++;
    if ({rsp_valid, busy, rsp_data, rsp_id} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b busy=%b data=%h id=%b want 0/0/00/0",
               rsp_valid, busy, rsp_data, rsp_id);
    end
    idle_inputs();
    reset = 1'b0;
    step();
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_accept: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  typedef struct {
    bit         id;
    logic [7:0] d;
    logic [2:0] s;
    logic       rt;
    logic [7:0] exp;
  } op_t;

  task automatic run_table(input string name, input op_t ops[$]);
    foreach (ops[k]) begin
      issue(ops[k].id, ops[k].d, ops[k].s, ops[k].rt);
      #1;
      n_tests++;
      if ({req_ready_0, req_ready_1} !== (ops[k].id ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL %s_ready[%0d]: got r0=%b r1=%b want id %0d", name, k,
                 req_ready_0, req_ready_1, ops[k].id);
      end
      step();
      idle_inputs();
      n_tests++;
      if (rsp_valid !== 1'b1 || busy !== 1'b1 || rsp_data !== ops[k].exp ||
          rsp_id !== ops[k].id) begin
        n_fail++;
        $display("FAIL %s_rsp[%0d]: got valid=%b busy=%b data=%h id=%b want 1/1/%h/%0d",
                 name, k, rsp_valid, busy, rsp_data, rsp_id, ops[k].exp, ops[k].id);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      n_tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_release[%0d]: got valid=%b busy=%b want 0/0", name, k,
                 rsp_valid, busy);
      end
    end
  endtask

  task automatic test_single_op();
    op_t ops[$];
    ops.push_back('{1'b0, 8'b1011_0011, 3'd3, 1'b0, 8'b1001_1000});
    ops.push_back('{1'b0, 8'b1011_0011, 3'd3, 1'b1, 8'b0001_0110});
    run_table("single", ops);
  endtask

  task automatic test_boundaries();
    op_t ops[$];
    ops.push_back('{1'b1, 8'h80, 3'd7, 1'b1, 8'h01});
    ops.push_back('{1'b0, 8'h01, 3'd7, 1'b0, 8'h80});
    ops.push_back('{1'b0, 8'h5A, 3'd0, 1'b0, 8'h5A});
    ops.push_back('{1'b1, 8'hC3, 3'd0, 1'b1, 8'hC3});
    run_table("boundary", ops);
  endtask

  task automatic test_simultaneous();
    reset = 1'b1;
    step();
    reset = 1'b0;
    issue(0, 8'hFF, 3'd1, 1'b0);
    issue(1, 8'hFF, 3'd1, 1'b1);
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      bit         id;
      logic [7:0] exp;
      id  = k[0];
      exp = id ? 8'h7F : 8'hFE;
      n_tests++;
      if ({req_ready_0, req_ready_1} !== (id ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL simul_grant[%0d]: got r0=%b r1=%b want id %0d", k,
                 req_ready_0, req_ready_1, id);
      end
      step();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== id || rsp_data !== exp ||
          {req_ready_0, req_ready_1} !== 2'b00) begin
        n_fail++;
        $display("FAIL simul_rsp[%0d]: got valid=%b id=%b data=%h rdy=%b%b want 1/%0d/%h/00",
                 k, rsp_valid, rsp_id, rsp_data, req_ready_0, req_ready_1, id, exp);
      end
      step();
    end
    idle_inputs();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(0, 8'h3C, 3'd2, 1'b0);
    step();
    idle_inputs();
    issue(1, 8'h81, 3'd1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (rsp_valid !== 1'b1 || busy !== 1'b1 || rsp_data !== 8'hF0 || rsp_id !== 1'b0 ||
          {req_ready_0, req_ready_1} !== 2'b00) begin
        n_fail++;
        $display("FAIL hold[%0d]: got valid=%b busy=%b data=%h id=%b rdy=%b%b want 1/1/f0/0/00",
                 k, rsp_valid, busy, rsp_data, rsp_id, req_ready_0, req_ready_1);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready_1 !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: got valid=%b r1=%b want 0/1", rsp_valid, req_ready_1);
    end
    step();
    idle_inputs();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 8'h40) begin
      n_fail++;
      $display("FAIL hold_next: got valid=%b id=%b data=%h want 1/1/40",
               rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    issue(0, 8'h11, 3'd1, 1'b0);
    step();
    idle_inputs();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy: got %b want 1", busy);
    end
    reset = 1'b1;
    issue(1, 8'h22, 3'd1, 1'b0);
    #1;
    step();
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b busy=%b r1=%b want 0/0/0",
               rsp_valid, busy, req_ready_1);
    end
    reset = 1'b0;
    issue(0, 8'h33, 3'd1, 1'b1);
    #1;
    n_tests++;
    if ({req_ready_0, req_ready_1} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_first_grant: got r0=%b r1=%b want 1/0", req_ready_0, req_ready_1);
    end
    step();
    idle_inputs();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 8'h19) begin
      n_fail++;
      $display("FAIL mid_first_rsp: got valid=%b id=%b data=%h want 1/0/19",
               rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    bit         pv [2];
    logic [7:0] pd [2];
    logic [2:0] ps [2];
    logic       pr [2];
    int         wait_ops [2];
    bit         holding;
    bit         last;
    logic [7:0] exp_data;
    bit         exp_id;
    int         accepted;
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
    holding  = 1'b0;
    last     = 1'b1;
    accepted = 0;
    for (int r = 0; r < 2; r++) begin
      pv[r] = 1'b0; wait_ops[r] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bit er0, er1, acc;
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && ($urandom % 4 != 0)) begin
          pv[r] = 1'b1;
          pd[r] = 8'($urandom);
          ps[r] = 3'($urandom);
          pr[r] = 1'($urandom);
        end
      end
      req_valid_0 = pv[0]; req_data_0 = pd[0]; req_shift_0 = ps[0]; req_right_0 = pr[0];
      req_valid_1 = pv[1]; req_data_1 = pd[1]; req_shift_1 = ps[1]; req_right_1 = pr[1];
      rsp_ready = ($urandom % 3 != 0);
      #1;
      er0 = !holding && pv[0] && (!pv[1] || last == 1'b1);
      er1 = !holding && pv[1] && (!pv[0] || last == 1'b0);
      n_tests++;
      if (req_ready_0 !== er0 || req_ready_1 !== er1 || rsp_valid !== holding ||
          busy !== holding) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got r0=%b r1=%b valid=%b busy=%b want %b/%b/%b/%b",
                 cyc, req_ready_0, req_ready_1, rsp_valid, busy, er0, er1, holding, holding);
      end
      if (holding) begin
        n_tests++;
        if (rsp_data !== exp_data || rsp_id !== exp_id) begin
          n_fail++;
          $display("FAIL rand_rsp[%0d]: got data=%h id=%b want %h/%0d",
                   cyc, rsp_data, rsp_id, exp_data, exp_id);
        end
      end
      acc = er0 || er1;
      if (acc) begin
        bit id;
        id = er1;
        for (int r = 0; r < 2; r++) if (pv[r]) wait_ops[r]++;
        n_tests++;
        if (wait_ops[id] > 2) begin
          n_fail++;
          $display("FAIL rand_starve[%0d]: requester %0d waited %0d ops want <= 2",
                   cyc, id, wait_ops[id]);
        end
        wait_ops[id] = 0;
        exp_data = ref_shift(pd[id], ps[id], pr[id]);
        exp_id   = id;
        last     = id;
        holding  = 1'b1;
        pv[id]   = 1'b0;
        accepted++;
      end else if (holding && rsp_ready) begin
        holding = 1'b0;
      end
      step();
    end
    n_tests++;
    if (accepted < 1000) begin
      n_fail++; $display("FAIL rand_activity: got %0d accepts want >= 1000", accepted);
    end
    idle_inputs();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single_op();
    test_boundaries();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_shift_arbiter.md
# logic_shift_arbiter

Two-requester round-robin arbiter and sequencer that shares a single `logic_shift` datapath instance. Each requester presents data, a shift amount and a direction over a valid/ready channel. The arbiter grants one request at a time, drives the shared shifter, registers the result, and returns it on a common response channel tagged with the requester ID. It sits between the shift clients and the combinational `logic_shift` block, which it instantiates internally.

## Interface
Parameters:
- BIT_NUM, 8, data width, passed to `logic_shift`
- SHIFT_BIT_NUM, 3, shift-amount width, passed to `logic_shift`

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req_valid_0 / req_valid_1  input  1  request present from requester 0 / 1
- req_ready_0 / req_ready_1  output  1  request accepted this cycle when ANDed with valid
- req_data_0 / req_data_1  input  BIT_NUM  operand
- req_shift_0 / req_shift_1  input  SHIFT_BIT_NUM  shift amount, 0..2^SHIFT_BIT_NUM-1
- req_right_0 / req_right_1  input  1  1 = logical right shift, 0 = logical left shift
- rsp_valid  output  1  result held on rsp_data / rsp_id
- rsp_ready  input  1  consumer accepts the result
- rsp_data  output  BIT_NUM  shifted result, zero-filled
- rsp_id  output  1  requester that issued the result
- busy  output  1  high while a result is held (state BUSY)

## Operation
- FSM states: IDLE, BUSY.
- IDLE: grant is chosen combinationally from the valid requests.
  - Only one valid: that requester is granted.
  - Both valid: the requester that is not `last_grant` is granted.
  - req_ready_i = (state==IDLE) & grant_i. At most one ready is high.
  - Ready depends combinationally on valid. Requesters must not make valid depend on ready.
- Accept (valid_i & ready_i) in IDLE:
  - The granted operand, amount and direction drive the shared `logic_shift`.
  - Its output is registered into rsp_data; i is registered into rsp_id.
  - last_grant is set to i and the FSM goes to BUSY.
- BUSY: rsp_valid=1; rsp_data and rsp_id are stable; both req_ready are 0.
  - rsp_valid & rsp_ready returns the FSM to IDLE.
  - No new request is accepted in that same cycle. Peak throughput is one op per 2 cycles.
- Shift semantics:
  - Left: data << amt, zeros in at the LSB.
  - Right: data >> amt, zeros in at the MSB.
  - amt=0 passes data unchanged.
- No request is dropped or duplicated. A requester holding valid is granted within 2 ops; round-robin guarantees no starvation.

## Timing
- Reset (synchronous, sampled at posedge):
  - state=IDLE, rsp_valid=0, busy=0, rsp_data=0, rsp_id=0.
  - last_grant=1, so requester 0 wins the first simultaneous request.
- Latency: request accepted at edge N gives rsp_valid=1 immediately after edge N (the cycle following acceptance).
- Response held for any number of cycles while rsp_ready=0. Data and ID must not change while held.
- Reset asserted while BUSY: the held result is discarded and rsp_valid=0 after that edge. Requests presented during reset are not accepted (ready=0 whenever reset=1).
- rsp_ready asserted while IDLE is ignored.

## Test plan
- Single op: reset, then req0 data=8'b1011_0011, shift=3, right=0 → one cycle after accept: rsp_valid=1, rsp_data=8'b1001_1000, rsp_id=0. Same with right=1 → 8'b0001_0110.
- Boundaries:
  - req1 data=8'h80, shift=7, right=1 → 8'h01, id=1.
  - data=8'h01, shift=7, left → 8'h80.
  - shift=0 → data unchanged.
- Simultaneous: both valid continuously from reset, req0=8'hFF/1/left, req1=8'hFF/1/right → responses in order id 0 (8'hFE), 1 (8'h7F), 0, 1, … Each accept is 2 cycles apart when rsp_ready=1.
- Backpressure: rsp_ready=0 for 5 cycles after a response appears → rsp_data/rsp_id stable, both req_ready=0, busy=1. Raising rsp_ready gives IDLE next cycle and a new grant the cycle after.
- Reset mid-operation: assert reset while BUSY with rsp_ready=0 → rsp_valid=0 after that edge. First post-reset simultaneous request grants requester 0.
- Random: 10,000 cycles of random valids, operands and rsp_ready → every accepted request produces exactly one response matching a reference shift model. No starvation: wait ≤ 2 ops per requester.
